// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen register-block RTL.
// Holds the response status codes, the external-access FSM states and address mapping.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        OKAY         = 2'b00,
        EXOKAY       = 2'b01,
        SLAVE_ERROR  = 2'b10,
        DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQUEST  = 2'b01,
        RESPONSE = 2'b10
    } rggen_ext_state;

    // Word-aligns an address and optionally rebases it onto the window start.
    // Wraps modulo 2**64; callers keep only their address width.
    function automatic logic [63:0] rggen_local_address(
        input logic [63:0] address,
        input logic [63:0] start,
        input bit          relative,
        input int          lsb
    );
        logic [63:0] aligned;
        aligned = address & ({64{1'b1}} << lsb);
        return relative ? (aligned - start) : aligned;
    endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// Simple valid/ready bus toward an external slave.
// Ports: master drives the request fields; slave returns ready/status/read_data.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     valid;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, write, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, write, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_register_if.sv
// Host-side register access bundle shared by every register in the block.
// Ports: host drives valid/write/address/write_data/strobe; register returns the rest.
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     valid;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     active;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;
    logic [BUS_WIDTH-1:0]     value;

    modport host (
        output valid, write, address, write_data, strobe,
        input  active, ready, status, read_data, value
    );

    modport register (
        input  valid, write, address, write_data, strobe,
        output active, ready, status, read_data, value
    );
endinterface

// File: rtl/rggen_address_decoder.sv
// Word-granular window match: START_ADDRESS <= address <= END_ADDRESS.
// Ports: i_address (byte address), o_match (combinational hit).
module rggen_address_decoder #(
    parameter int                     ADDRESS_WIDTH = 8,
    parameter int                     LSB           = 2,
    parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
    parameter bit [ADDRESS_WIDTH-1:0] END_ADDRESS   = '0
)(
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    output logic                     o_match
);
    localparam bit [ADDRESS_WIDTH-1:0] FIRST_WORD = START_ADDRESS >> LSB;
    localparam bit [ADDRESS_WIDTH-1:0] LAST_WORD  = END_ADDRESS >> LSB;
    localparam bit [ADDRESS_WIDTH-1:0] SPAN       = LAST_WORD - FIRST_WORD;

    logic [ADDRESS_WIDTH-1:0] word;
    logic [ADDRESS_WIDTH-1:0] offset;

    // One unsigned compare on the wrapped offset covers both bounds.
    assign word    = i_address >> LSB;
    assign offset  = word - FIRST_WORD;
    assign o_match = offset <= SPAN;
endmodule

// File: rtl/rggen_wait_timer.sv
// Bounded-wait watchdog: counts active cycles without done and flags the last one.
// Ports: i_start clears, i_active/i_done qualify counting, o_timeout marks the abort cycle.
module rggen_wait_timer #(
    parameter int COUNT = 0,
    parameter int WIDTH = 16
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_active,
    input  logic i_done,
    output logic o_timeout
);
    if (COUNT == 0) begin : g_stub
        logic unused_inputs;
        assign unused_inputs = ^{i_clk, i_rst_n, i_start, i_active, i_done};
        assign o_timeout     = 1'b0;
    end else begin : g_timer
        localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT - 1);

        logic [WIDTH-1:0] count_d;
        logic [WIDTH-1:0] count_q;
        logic             waiting;

        assign waiting = i_active && !i_done;

        always_comb begin
            count_d = count_q;
            if (i_start) begin
                count_d = '0;
            end else if (waiting) begin
                count_d = count_q + WIDTH'(1);
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        // A ready arriving in the last cycle wins over the abort.
        assign o_timeout = waiting && (count_q == LAST);
    end
endmodule

// File: rtl/rggen_external_register_tmo.sv
// Bridges a register-map window to an external bus slave with a watchdog.
// Ports: i_clk, i_rst_n, register_if (host side), bus_if (slave side), o_timeout pulse.
module rggen_external_register_tmo
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH     = 8,
    parameter int                     BUS_WIDTH         = 32,
    parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS     = '0,
    parameter bit [ADDRESS_WIDTH-1:0] END_ADDRESS       = '0,
    parameter bit                     RELATIVE_ADDRESS  = 1'b1,
    parameter int                     TIMEOUT_CYCLES    = 0,
    parameter int                     TIMEOUT_WIDTH     = 16,
    parameter bit                     RESPONSE_REGISTER = 1'b0
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    rggen_register_if.register register_if,
    rggen_bus_if.master        bus_if,
    output logic               o_timeout
);
    localparam int LSB    = $clog2(BUS_WIDTH) - 3;
    localparam int STRB_W = BUS_WIDTH / 8;

    rggen_ext_state state_d;
    rggen_ext_state state_q;
    logic           valid_d;
    logic           valid_q;
    rggen_status    status_d;
    rggen_status    status_q;
    logic [BUS_WIDTH-1:0] data_d;
    logic [BUS_WIDTH-1:0] data_q;

    logic [ADDRESS_WIDTH-1:0] address_d;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic                     write_d;
    logic                     write_q;
    logic [BUS_WIDTH-1:0]     write_data_d;
    logic [BUS_WIDTH-1:0]     write_data_q;
    logic [STRB_W-1:0]        strobe_d;
    logic [STRB_W-1:0]        strobe_q;

    logic                 match;
    logic                 accept;
    logic                 timeout;
    logic                 finish;
    logic [63:0]          local_address;
    logic                 unused_address;
    rggen_status          rsp_status;
    logic [BUS_WIDTH-1:0] rsp_data;
    logic                 out_ready;
    rggen_status          out_status;
    logic [BUS_WIDTH-1:0] out_data;

    rggen_address_decoder #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LSB           (LSB),
        .START_ADDRESS (START_ADDRESS),
        .END_ADDRESS   (END_ADDRESS)
    ) u_decoder (
        .i_address (register_if.address),
        .o_match   (match)
    );

    rggen_wait_timer #(
        .COUNT (TIMEOUT_CYCLES),
        .WIDTH (TIMEOUT_WIDTH)
    ) u_wait_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (accept),
        .i_active  (state_q == REQUEST),
        .i_done    (bus_if.ready),
        .o_timeout (timeout)
    );

    assign register_if.active = match;
    assign accept = (state_q == IDLE) && register_if.valid && match;
    assign finish = bus_if.ready || timeout;

    assign local_address = rggen_local_address(
        64'(register_if.address), 64'(START_ADDRESS), RELATIVE_ADDRESS, LSB
    );
    assign unused_address = ^local_address[63:ADDRESS_WIDTH];

    // An aborted access reports SLAVE_ERROR with all-zero data.
    assign rsp_status = bus_if.ready ? bus_if.status : SLAVE_ERROR;
    assign rsp_data   = bus_if.ready ? bus_if.read_data : '0;

    always_comb begin
        address_d    = address_q;
        write_d      = write_q;
        write_data_d = write_data_q;
        strobe_d     = strobe_q;
        if (accept) begin
            address_d    = local_address[ADDRESS_WIDTH-1:0];
            write_d      = register_if.write;
            write_data_d = register_if.write_data;
            strobe_d     = register_if.strobe;
        end
    end

    always_ff @(posedge i_clk) begin
        address_q    <= address_d;
        write_q      <= write_d;
        write_data_q <= write_data_d;
        strobe_q     <= strobe_d;
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        status_d = status_q;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQUEST;
                    valid_d = 1'b1;
                end
            end
            REQUEST: begin
                if (finish) begin
                    valid_d = 1'b0;
                    if (RESPONSE_REGISTER) begin
                        state_d  = RESPONSE;
                        status_d = rsp_status;
                        data_d   = rsp_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESPONSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            status_q <= OKAY;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            status_q <= status_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        if (RESPONSE_REGISTER) begin
            out_ready  = state_q == RESPONSE;
            out_status = status_q;
            out_data   = data_q;
        end else begin
            out_ready  = (state_q == REQUEST) && finish;
            out_status = rsp_status;
            out_data   = rsp_data;
        end
    end

    assign register_if.ready     = out_ready;
    assign register_if.status    = out_ready ? out_status : OKAY;
    assign register_if.read_data = out_ready ? out_data : '0;
    assign register_if.value     = out_ready ? out_data : '0;

    assign bus_if.valid      = valid_q;
    assign bus_if.write      = write_q;
    assign bus_if.address    = address_q;
    assign bus_if.write_data = write_data_q;
    assign bus_if.strobe     = strobe_q;

    assign o_timeout = timeout;
endmodule

// File: tb/tb_rggen_external_register_tmo.sv
// Randomized bench for rggen_external_register_tmo against a transaction-level model.
// Two DUTs share stimulus: one with a combinational response, one with a registered one.
module tb_rggen_external_register_tmo;
    import rggen_rtl_pkg::*;

    localparam int AW   = 8;
    localparam int BW   = 32;
    localparam int TMO  = 8;
    localparam int NCYC = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tmo0;
    logic tmo1;

    always #5 clk = ~clk;

    rggen_register_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) rif0 ();
    rggen_register_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) rif1 ();
    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bif0 ();
    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bif1 ();

    rggen_external_register_tmo #(
        .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
        .START_ADDRESS(8'h10), .END_ADDRESS(8'h1F),
        .RELATIVE_ADDRESS(1'b1), .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_WIDTH(16), .RESPONSE_REGISTER(1'b0)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .register_if(rif0), .bus_if(bif0), .o_timeout(tmo0)
    );

    rggen_external_register_tmo #(
        .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
        .START_ADDRESS(8'h10), .END_ADDRESS(8'h1F),
        .RELATIVE_ADDRESS(1'b1), .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_WIDTH(16), .RESPONSE_REGISTER(1'b1)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .register_if(rif1), .bus_if(bif1), .o_timeout(tmo1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic        s_bv[2];
    logic        s_bw[2];
    logic        s_rr[2];
    logic        s_act[2];
    logic        s_to[2];
    logic [7:0]  s_ba[2];
    logic [31:0] s_bd[2];
    logic [3:0]  s_bs[2];
    logic [31:0] s_val[2];
    rggen_status s_st[2];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_drive(input logic v, input logic w, input logic [7:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        rif0.valid = v; rif0.write = w; rif0.address = a;
        rif0.write_data = d; rif0.strobe = s;
        rif1.valid = v; rif1.write = w; rif1.address = a;
        rif1.write_data = d; rif1.strobe = s;
    endtask

    task automatic slave_drive(input logic r0, input logic r1,
                               input logic [31:0] d, input rggen_status st);
        bif0.ready = r0; bif0.read_data = d; bif0.status = st;
        bif1.ready = r1; bif1.read_data = d; bif1.status = st;
    endtask

    task automatic sample();
        s_bv[0] = bif0.valid; s_bw[0] = bif0.write; s_ba[0] = bif0.address;
        s_bd[0] = bif0.write_data; s_bs[0] = bif0.strobe;
        s_rr[0] = rif0.ready; s_act[0] = rif0.active; s_val[0] = rif0.value;
        s_st[0] = rif0.status; s_to[0] = tmo0;
        s_bv[1] = bif1.valid; s_bw[1] = bif1.write; s_ba[1] = bif1.address;
        s_bd[1] = bif1.write_data; s_bs[1] = bif1.strobe;
        s_rr[1] = rif1.ready; s_act[1] = rif1.active; s_val[1] = rif1.value;
        s_st[1] = rif1.status; s_to[1] = tmo1;
    endtask

    // Model: slave raises ready after wait_n waiting cycles; the watchdog
    // allows TMO request cycles; latency = 1 + waits + response stage.
    task automatic run_txn(input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int wait_n, input logic [31:0] rdata,
                           input rggen_status st);
        bit          in_win;
        bit          tmo;
        int          eff;
        int          exp_addr;
        rggen_status exp_st;
        logic [31:0] exp_data;
        int          slv[2];
        int          vcnt[2];
        int          rcnt[2];
        int          rcyc[2];
        int          tcnt[2];
        int          leak[2];
        int          moved[2];
        logic        act0[2];
        logic [7:0]  fa[2];
        logic        fw[2];
        logic [31:0] fd[2];
        logic [3:0]  fs[2];
        rggen_status gst[2];
        logic [31:0] gval[2];
        in_win   = (int'(addr) >= 'h10) && (int'(addr) <= 'h1F);
        tmo      = wait_n >= TMO;
        eff      = tmo ? TMO - 1 : wait_n;
        exp_st   = tmo ? SLAVE_ERROR : st;
        exp_data = tmo ? 32'h0 : rdata;
        exp_addr = ((int'(addr) / 4) * 4 - 'h10) & 'hFF;
        for (int i = 0; i < 2; i++) begin
            slv[i] = 0; vcnt[i] = 0; rcnt[i] = 0; rcyc[i] = -1;
            tcnt[i] = 0; leak[i] = 0; moved[i] = 0; act0[i] = 1'b0;
            fa[i] = '0; fw[i] = 1'b0; fd[i] = '0; fs[i] = '0;
            gst[i] = OKAY; gval[i] = '0;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            host_drive(c == 0, wr, addr, wdata, strb);
            slave_drive(bif0.valid && (slv[0] == wait_n),
                        bif1.valid && (slv[1] == wait_n), rdata, st);
            #1;
            sample();
            for (int i = 0; i < 2; i++) begin
                if (c == 0) act0[i] = s_act[i];
                if (s_bv[i]) begin
                    if (vcnt[i] == 0) begin
                        fa[i] = s_ba[i]; fw[i] = s_bw[i];
                        fd[i] = s_bd[i]; fs[i] = s_bs[i];
                    end else if (fa[i] !== s_ba[i] || fw[i] !== s_bw[i] ||
                                 fd[i] !== s_bd[i] || fs[i] !== s_bs[i]) begin
                        moved[i]++;
                    end
                    vcnt[i]++;
                    slv[i]++;
                end else begin
                    slv[i] = 0;
                end
                if (s_rr[i]) begin
                    rcnt[i]++;
                    if (rcyc[i] < 0) begin
                        rcyc[i] = c; gst[i] = s_st[i]; gval[i] = s_val[i];
                    end
                end else if (s_val[i] !== 32'h0) begin
                    leak[i]++;
                end
                if (s_to[i]) tcnt[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rr%0d.active@%0h", i, addr), 64'(act0[i]), 64'(in_win));
            check($sformatf("rr%0d.bus_valid_cycles", i), 64'(vcnt[i]),
                  64'(in_win ? eff + 1 : 0));
            check($sformatf("rr%0d.bus_hold", i), 64'(moved[i]), 64'(0));
            check($sformatf("rr%0d.ready_count", i), 64'(rcnt[i]), 64'(in_win));
            check($sformatf("rr%0d.timeout_count", i), 64'(tcnt[i]),
                  64'(in_win && tmo));
            check($sformatf("rr%0d.value_idle", i), 64'(leak[i]), 64'(0));
            if (in_win) begin
                check($sformatf("rr%0d.bus_addr", i), 64'(fa[i]), 64'(exp_addr));
                check($sformatf("rr%0d.bus_write", i), 64'(fw[i]), 64'(wr));
                check($sformatf("rr%0d.bus_wdata", i), 64'(fd[i]), 64'(wdata));
                check($sformatf("rr%0d.bus_strobe", i), 64'(fs[i]), 64'(strb));
                check($sformatf("rr%0d.latency", i), 64'(rcyc[i]),
                      64'(1 + eff + i));
                check($sformatf("rr%0d.status", i), 64'(gst[i]), 64'(exp_st));
                check($sformatf("rr%0d.value", i), 64'(gval[i]), 64'(exp_data));
            end
        end
    endtask

    task automatic reset_mid_access();
        @(negedge clk);
        host_drive(1'b1, 1'b0, 8'h14, 32'h0, 4'hF);
        slave_drive(1'b0, 1'b0, 32'h1234_5678, OKAY);
        @(negedge clk);
        host_drive(1'b0, 1'b0, 8'h14, 32'h0, 4'hF);
        @(negedge clk);
        #1;
        sample();
        check("pre_reset.bus_valid0", 64'(s_bv[0]), 64'(1));
        check("pre_reset.bus_valid1", 64'(s_bv[1]), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        sample();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rr%0d.async_valid", i), 64'(s_bv[i]), 64'(0));
            check($sformatf("rr%0d.async_ready", i), 64'(s_rr[i]), 64'(0));
            check($sformatf("rr%0d.async_timeout", i), 64'(s_to[i]), 64'(0));
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            sample();
            check("in_reset.ready", 64'({s_rr[1], s_rr[0]}), 64'(0));
        end
        rst_n = 1'b1;
    endtask

    initial begin
        host_drive(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        slave_drive(1'b0, 1'b0, 32'h0, OKAY);
        repeat (3) @(negedge clk);
        #1;
        sample();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rr%0d.reset_bus_valid", i), 64'(s_bv[i]), 64'(0));
            check($sformatf("rr%0d.reset_ready", i), 64'(s_rr[i]), 64'(0));
            check($sformatf("rr%0d.reset_timeout", i), 64'(s_to[i]), 64'(0));
            check($sformatf("rr%0d.reset_value", i), 64'(s_val[i]), 64'(0));
        end
        rst_n = 1'b1;

        run_txn(1'b0, 8'h14, 32'h0, 4'hF, 4, 32'hCAFE_0001, OKAY);
        run_txn(1'b1, 8'h18, 32'hA5A5_A5A5, 4'b0011, 0, 32'h0, OKAY);
        run_txn(1'b0, 8'h1C, 32'h0, 4'hF, 40, 32'hDEAD_BEEF, OKAY);
        run_txn(1'b0, 8'h10, 32'h0, 4'hF, 7, 32'h0BAD_F00D, EXOKAY);
        run_txn(1'b0, 8'h1F, 32'h0, 4'hF, 8, 32'h1111_2222, OKAY);
        run_txn(1'b0, 8'h20, 32'h0, 4'hF, 0, 32'h3333_4444, OKAY);
        run_txn(1'b1, 8'h0F, 32'h5555_6666, 4'hF, 0, 32'h0, OKAY);

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), 8'($urandom_range(8'h08, 8'h27)),
                    $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 11)), $urandom,
                    rggen_status'($urandom_range(0, 3)));
        end

        reset_mid_access();
        run_txn(1'b0, 8'h14, 32'h0, 4'hF, 2, 32'h7777_8888, OKAY);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
